// File: rtl/pw_checker_if.sv
// Scanner <-> password checker handshake bundle.
// The scanner drives the request and both passwords; the checker returns done/match/busy.
interface pw_checker_if #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
);
  localparam int PW_W = DIGITS * DIGIT_W;

  logic            compare_start;
  logic [PW_W-1:0] stored_pw;
  logic [PW_W-1:0] entered_pw;
  logic            compare_done;
  logic            compare_match;
  logic            busy;

  modport master (
    output compare_start, stored_pw, entered_pw,
    input  compare_done, compare_match, busy
  );

  modport slave (
    input  compare_start, stored_pw, entered_pw,
    output compare_done, compare_match, busy
  );
endinterface

// File: rtl/pw_checker.sv
// Digit-serial BCD password comparator; always walks every digit so latency is
// independent of where (or whether) the passwords differ.
//
// state  | meaning
// IDLE   | waiting for compare_start; capture both passwords on its rising sample
// CHECK  | compare one digit per clock, accumulate mismatch, abort if start drops
// RESULT | hold done/match until the scanner drops compare_start
module pw_checker #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  pw_checker_if.slave pw_if
);
  localparam int PW_W  = DIGITS * DIGIT_W;
  localparam int CNT_W = $clog2(DIGITS) + 1;

  typedef enum logic [1:0] {IDLE, CHECK, RESULT} state_t;

  state_t             state_q, state_d;
  logic [PW_W-1:0]    stored_sr_q, stored_sr_d;
  logic [PW_W-1:0]    entered_sr_q, entered_sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mismatch_q, mismatch_d;
  logic               done_q, done_d;
  logic               match_q, match_d;
  logic               busy_q, busy_d;

  logic [DIGIT_W-1:0] digit_s, digit_e;
  logic               mismatch_next;

  assign digit_s = stored_sr_q[PW_W-1 -: DIGIT_W];
  assign digit_e = entered_sr_q[PW_W-1 -: DIGIT_W];

  // Non-BCD digits (e.g. 4'hF blank entries) can never produce a match.
  assign mismatch_next = mismatch_q
                       | (digit_s != digit_e)
                       | (digit_s > DIGIT_W'(9))
                       | (digit_e > DIGIT_W'(9));

  always_comb begin
    state_d      = state_q;
    stored_sr_d  = stored_sr_q;
    entered_sr_d = entered_sr_q;
    cnt_d        = cnt_q;
    mismatch_d   = mismatch_q;
    done_d       = done_q;
    match_d      = match_q;
    busy_d       = busy_q;

    unique case (state_q)
      IDLE: begin
        done_d  = 1'b0;
        match_d = 1'b0;
        busy_d  = 1'b0;
        if (pw_if.compare_start) begin
          stored_sr_d  = pw_if.stored_pw;
          entered_sr_d = pw_if.entered_pw;
          cnt_d        = '0;
          mismatch_d   = 1'b0;
          busy_d       = 1'b1;
          state_d      = CHECK;
        end
      end

      CHECK: begin
        if (!pw_if.compare_start) begin
          state_d = IDLE;
          done_d  = 1'b0;
          match_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          stored_sr_d  = stored_sr_q << DIGIT_W;
          entered_sr_d = entered_sr_q << DIGIT_W;
          cnt_d        = cnt_q + CNT_W'(1);
          mismatch_d   = mismatch_next;
          if (cnt_q == CNT_W'(DIGITS - 1)) begin
            state_d = RESULT;
            done_d  = 1'b1;
            match_d = ~mismatch_next;
            busy_d  = 1'b0;
          end
        end
      end

      RESULT: begin
        if (!pw_if.compare_start) begin
          state_d = IDLE;
          done_d  = 1'b0;
          match_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        match_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      stored_sr_q  <= '0;
      entered_sr_q <= '0;
      cnt_q        <= '0;
      mismatch_q   <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      stored_sr_q  <= stored_sr_d;
      entered_sr_q <= entered_sr_d;
      cnt_q        <= cnt_d;
      mismatch_q   <= mismatch_d;
      done_q       <= done_d;
      match_q      <= match_d;
      busy_q       <= busy_d;
    end
  end

  assign pw_if.compare_done  = done_q;
  assign pw_if.compare_match = match_q;
  assign pw_if.busy          = busy_q;
endmodule
